// File: rtl/mfp_ahb_arbiter.sv
// ============================================================================
// mfp_ahb_arbiter - two-master AHB-lite arbiter in front of the mfp_ahb bus
// Revision: 1.0
// ============================================================================
`default_nettype none

module mfp_ahb_arbiter #(
  parameter int BURST_LIMIT = 16
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [31:0] M0_HADDR,
  input  logic [1:0]  M0_HTRANS,
  input  logic        M0_HWRITE,
  input  logic [2:0]  M0_HSIZE,
  input  logic [31:0] M0_HWDATA,
  output logic        M0_HREADY,
  input  logic [31:0] M1_HADDR,
  input  logic [1:0]  M1_HTRANS,
  input  logic        M1_HWRITE,
  input  logic [2:0]  M1_HSIZE,
  input  logic [31:0] M1_HWDATA,
  output logic        M1_HREADY,
  output logic [31:0] S_HADDR,
  output logic [1:0]  S_HTRANS,
  output logic        S_HWRITE,
  output logic [2:0]  S_HSIZE,
  output logic [31:0] S_HWDATA,
  input  logic        S_HREADY,
  output logic        GRANT
);

  localparam int              BEAT_W    = $clog2(BURST_LIMIT + 1);
  localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(BURST_LIMIT);
  localparam logic [BEAT_W-1:0] BEAT_ONE = BEAT_W'(1);
  localparam logic [1:0]      HT_IDLE   = 2'b00;
  localparam logic [1:0]      HT_NONSEQ = 2'b10;
  localparam logic [1:0]      HT_SEQ    = 2'b11;

  logic              last;
  logic              down;
  logic              dval;
  logic [BEAT_W-1:0] beats;
  logic              wait_q;
  logic              own_q;

  logic              req0;
  logic              req1;
  logic [1:0]        last_htrans;
  logic              burst_cont;
  logic              own_arb;
  logic              own;
  logic [1:0]        own_htrans;
  logic              req_own;
  logic [1:0]        s_htrans;
  logic              same_burst;

  assign req0 = M0_HTRANS[1];
  assign req1 = M1_HTRANS[1];

  always_comb begin
    last_htrans = last ? M1_HTRANS : M0_HTRANS;
    burst_cont  = (last_htrans == HT_SEQ) && (beats < BEAT_MAX);
    own_arb     = last;
    if (burst_cont)
      own_arb = last;
    else if (req0 && !req1)
      own_arb = 1'b0;
    else if (req1 && !req0)
      own_arb = 1'b1;
    else if (req0 && req1)
      own_arb = ~last;
  end

  // Once a wait state starts the owner is frozen until the slave is ready again.
  assign own        = wait_q ? own_q : own_arb;
  assign own_htrans = own ? M1_HTRANS : M0_HTRANS;
  assign req_own    = own_htrans[1];

  // A preempted master retries with a stale SEQ; it is presented as NONSEQ.
  always_comb begin
    s_htrans = own_htrans;
    if (!HRESETn || !req_own)
      s_htrans = HT_IDLE;
    else if ((own_htrans == HT_SEQ) && (own != last))
      s_htrans = HT_NONSEQ;
  end

  assign same_burst = (own == last) && (s_htrans == HT_SEQ);

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      last   <= 1'b1;
      down   <= 1'b0;
      dval   <= 1'b0;
      beats  <= '0;
      wait_q <= 1'b0;
      own_q  <= 1'b0;
    end else begin
      wait_q <= ~S_HREADY;
      own_q  <= own;
      if (S_HREADY) begin
        dval <= req_own;
        down <= own;
        if (req_own)
          last <= own;
        if (same_burst)
          beats <= (beats == BEAT_MAX) ? beats : beats + BEAT_ONE;
        else
          beats <= BEAT_ONE;
      end
    end
  end

  assign S_HADDR   = own ? M1_HADDR  : M0_HADDR;
  assign S_HWRITE  = own ? M1_HWRITE : M0_HWRITE;
  assign S_HSIZE   = own ? M1_HSIZE  : M0_HSIZE;
  assign S_HTRANS  = s_htrans;
  assign S_HWDATA  = dval ? (down ? M1_HWDATA : M0_HWDATA) : 32'h0;
  assign GRANT     = own;

  assign M0_HREADY = (req0 && own)  ? 1'b0 : S_HREADY;
  assign M1_HREADY = (req1 && !own) ? 1'b0 : S_HREADY;

endmodule

`default_nettype wire

// File: tb/tb_mfp_ahb_arbiter.sv
// ============================================================================
// tb_mfp_ahb_arbiter - directed self-checking bench for mfp_ahb_arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mfp_ahb_arbiter;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic [31:0] m0_haddr, m1_haddr;
  logic [1:0]  m0_htrans, m1_htrans;
  logic        m0_hwrite, m1_hwrite;
  logic [2:0]  m0_hsize, m1_hsize;
  logic [31:0] m0_hwdata, m1_hwdata;
  logic        m0_hready, m1_hready;
  logic [31:0] s_haddr;
  logic [1:0]  s_htrans;
  logic        s_hwrite;
  logic [2:0]  s_hsize;
  logic [31:0] s_hwdata;
  logic        s_hready;
  logic        grant;

  int errors = 0;
  int checks = 0;

  mfp_ahb_arbiter #(.BURST_LIMIT(4)) dut (
    .HCLK(hclk), .HRESETn(hresetn),
    .M0_HADDR(m0_haddr), .M0_HTRANS(m0_htrans), .M0_HWRITE(m0_hwrite),
    .M0_HSIZE(m0_hsize), .M0_HWDATA(m0_hwdata), .M0_HREADY(m0_hready),
    .M1_HADDR(m1_haddr), .M1_HTRANS(m1_htrans), .M1_HWRITE(m1_hwrite),
    .M1_HSIZE(m1_hsize), .M1_HWDATA(m1_hwdata), .M1_HREADY(m1_hready),
    .S_HADDR(s_haddr), .S_HTRANS(s_htrans), .S_HWRITE(s_hwrite),
    .S_HSIZE(s_hsize), .S_HWDATA(s_hwdata), .S_HREADY(s_hready),
    .GRANT(grant)
  );

  always #5 hclk = ~hclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge hclk);
    #1;
  endtask

  task automatic m0_set(input logic [1:0] tr, input logic [31:0] a, input logic w, input logic [31:0] d);
    m0_htrans = tr; m0_haddr = a; m0_hwrite = w; m0_hwdata = d; m0_hsize = 3'd2;
  endtask

  task automatic m1_set(input logic [1:0] tr, input logic [31:0] a, input logic w, input logic [31:0] d);
    m1_htrans = tr; m1_haddr = a; m1_hwrite = w; m1_hwdata = d; m1_hsize = 3'd2;
  endtask

  task automatic do_reset();
    hresetn  = 1'b0;
    s_hready = 1'b1;
    m0_set(2'd0, 32'h0, 1'b0, 32'h0);
    m1_set(2'd0, 32'h0, 1'b0, 32'h0);
    cyc();
    cyc();
    hresetn = 1'b1;
  endtask

  logic [6:0] g4 = 7'b0010000;
  logic [1:0] t4 [7] = '{2'd2, 2'd3, 2'd3, 2'd3, 2'd2, 2'd2, 2'd3};
  int cnt0, cnt1;

  initial begin
    // Reset state
    do_reset();
    #1;
    chk("rst_grant", grant, 1);
    chk("rst_htrans", s_htrans, 0);
    chk("rst_hwdata", s_hwdata, 0);
    chk("rst_m0_hready", m0_hready, 1);
    chk("rst_m1_hready", m1_hready, 1);

    // 1) Uncontested M0 write
    m0_set(2'd2, 32'hBF80_0000, 1'b1, 32'h0);
    #1;
    chk("t1_haddr", s_haddr, 32'hBF80_0000);
    chk("t1_htrans", s_htrans, 2);
    chk("t1_hwrite", s_hwrite, 1);
    chk("t1_grant", grant, 0);
    chk("t1_m0_hready_a", m0_hready, 1);
    cyc();
    m0_set(2'd0, 32'h0, 1'b0, 32'h1234);
    #1;
    chk("t1_hwdata", s_hwdata, 32'h1234);
    chk("t1_m0_hready_d", m0_hready, 1);
    chk("t1_htrans_idle", s_htrans, 0);
    cyc();
    chk("t1_hwdata_clr", s_hwdata, 0);

    // 2) Simultaneous NONSEQ after reset
    do_reset();
    m0_set(2'd2, 32'h1000, 1'b1, 32'h0);
    m1_set(2'd2, 32'h2000, 1'b1, 32'h0);
    #1;
    chk("t2_grant0", grant, 0);
    chk("t2_m1_stall", m1_hready, 0);
    chk("t2_haddr0", s_haddr, 32'h1000);
    cyc();
    m0_set(2'd0, 32'h0, 1'b0, 32'hAAAA_0000);
    #1;
    chk("t2_grant1", grant, 1);
    chk("t2_haddr1", s_haddr, 32'h2000);
    chk("t2_m1_hready", m1_hready, 1);
    chk("t2_hwdata0", s_hwdata, 32'hAAAA_0000);
    cyc();
    m1_set(2'd0, 32'h0, 1'b0, 32'hBBBB);
    #1;
    chk("t2_hwdata1", s_hwdata, 32'hBBBB);

    // 3) Continuous competing NONSEQs alternate
    do_reset();
    m0_set(2'd2, 32'h1100, 1'b0, 32'h0);
    m1_set(2'd2, 32'h2200, 1'b0, 32'h0);
    cnt0 = 0; cnt1 = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("t3_grant_%0d", i), grant, i % 2);
      if (i % 2 == 0) begin
        cnt0++;
        chk($sformatf("t3_m1_stall_%0d", i), m1_hready, 0);
      end else begin
        cnt1++;
        chk($sformatf("t3_m0_stall_%0d", i), m0_hready, 0);
      end
      cyc();
    end
    chk("t3_cnt0", cnt0, 4);
    chk("t3_cnt1", cnt1, 4);

    // 4) Burst limit preemption and NONSEQ retry
    do_reset();
    for (int i = 0; i < 7; i++) begin
      m0_set((i == 0) ? 2'd2 : 2'd3,
             (i <= 4) ? 32'h100 + 32'(4 * i) : ((i == 5) ? 32'h110 : 32'h114), 1'b1, 32'h0);
      if (i <= 4) m1_set(2'd2, 32'h2000, 1'b0, 32'h0);
      else        m1_set(2'd0, 32'h0, 1'b0, 32'h0);
      #1;
      chk($sformatf("t4_grant_%0d", i), grant, g4[i]);
      chk($sformatf("t4_htrans_%0d", i), s_htrans, t4[i]);
      if (i == 4) begin
        chk("t4_haddr_m1", s_haddr, 32'h2000);
        chk("t4_m0_stall", m0_hready, 0);
      end
      if (i == 5) chk("t4_haddr_retry", s_haddr, 32'h110);
      cyc();
    end

    // 4b) Solo burst beyond the limit keeps SEQ; beat count saturates
    do_reset();
    m1_set(2'd0, 32'h0, 1'b0, 32'h0);
    for (int i = 0; i < 9; i++) begin
      m0_set((i == 0) ? 2'd2 : 2'd3, 32'h600 + 32'(4 * i), 1'b0, 32'h0);
      #1;
      chk($sformatf("t4b_htrans_%0d", i), s_htrans, (i == 0) ? 2 : 3);
      cyc();
    end
    m0_set(2'd3, 32'h624, 1'b0, 32'h0);
    m1_set(2'd2, 32'h7000, 1'b0, 32'h0);
    #1;
    chk("t4b_preempt", grant, 1);

    // 5) Wait states freeze the bus
    do_reset();
    m0_set(2'd2, 32'h3000, 1'b1, 32'h0);
    #1;
    chk("t5_grant_a", grant, 0);
    cyc();
    m0_set(2'd2, 32'h3004, 1'b1, 32'h55);
    s_hready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) m1_set(2'd2, 32'h4000, 1'b0, 32'h0);
      #1;
      chk($sformatf("t5_grant_%0d", i), grant, 0);
      chk($sformatf("t5_haddr_%0d", i), s_haddr, 32'h3004);
      chk($sformatf("t5_hwdata_%0d", i), s_hwdata, 32'h55);
      chk($sformatf("t5_m0_hready_%0d", i), m0_hready, 0);
      chk($sformatf("t5_m1_hready_%0d", i), m1_hready, 0);
      cyc();
    end
    s_hready = 1'b1;
    #1;
    chk("t5_resume_grant", grant, 0);
    chk("t5_resume_m0", m0_hready, 1);
    chk("t5_resume_m1", m1_hready, 0);
    cyc();
    m0_set(2'd0, 32'h0, 1'b0, 32'h66);
    #1;
    chk("t5_next_grant", grant, 1);
    chk("t5_next_hwdata", s_hwdata, 32'h66);

    // 6) Reset in the middle of an M1 burst
    do_reset();
    m1_set(2'd2, 32'h5000, 1'b1, 32'h0);
    #1;
    chk("t6_grant_a", grant, 1);
    cyc();
    m1_set(2'd3, 32'h5004, 1'b1, 32'h77);
    #1;
    chk("t6_htrans_seq", s_htrans, 3);
    cyc();
    hresetn = 1'b0;
    m1_set(2'd3, 32'h5008, 1'b1, 32'h88);
    #1;
    chk("t6_htrans_in_rst", s_htrans, 0);
    cyc();
    hresetn = 1'b1;
    m1_set(2'd0, 32'h0, 1'b0, 32'h99);
    #1;
    chk("t6_htrans_after", s_htrans, 0);
    chk("t6_grant_after", grant, 1);
    chk("t6_hwdata_after", s_hwdata, 0);
    cyc();
    m0_set(2'd2, 32'h1000, 1'b0, 32'h0);
    m1_set(2'd2, 32'h2000, 1'b0, 32'h0);
    #1;
    chk("t6_tie_to_m0", grant, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
